// File: rtl/reg_write_arbiter.sv
// Round-robin owner of the register bank's single write port: one winner per
// transaction, registered write strobe/address/data and a one-hot grant pulse.
//
// state  | meaning
// IDLE   | arbitrating; a set req bit starts a write at this edge
// WRITE  | wr_en/gnt high for the winner, bank captures at the next edge
// SETTLE | one non-write bubble so the winner can drop req
module reg_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           gnt,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  winner;
    logic              found;
    int                idx;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Scan upward from the slot after the previous winner, wrapping once.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(last) + off) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
        win_addr = req_addr[int'(winner)*ADDR_W +: ADDR_W];
        win_data = req_data[int'(winner)*DATA_W +: DATA_W];
    end

    // busy spans the whole transaction up to the next edge that can arbitrate,
    // so it also covers the first IDLE cycle after SETTLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= LAST_RST;
            gnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= WRITE;
                        last    <= winner;
                        gnt     <= N_REQ'(1) << winner;
                        wr_en   <= 1'b1;
                        wr_addr <= win_addr;
                        wr_data <= win_data;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                WRITE: begin
                    state   <= SETTLE;
                    gnt     <= '0;
                    wr_en   <= 1'b0;
                    wr_addr <= '0;
                    wr_data <= '0;
                    busy    <= 1'b1;
                end
                SETTLE: begin
                    state <= IDLE;
                    busy  <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    wr_en   <= 1'b0;
                    wr_addr <= '0;
                    wr_data <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
